// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request/grant/rvalid bus transaction at a time.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of forcing natural alignment.
module load_store_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_width,
  input  logic        req_unsigned,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RD_W = 5;
  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_BYTE = 2'd1;
  localparam logic [1:0] MEM_HALF = 2'd2;
  localparam logic [1:0] MEM_WORD = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [1:0]        width_q, width_d;
  logic [1:0]        off_q, off_d;
  logic              unsigned_q, unsigned_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic [RD_W-1:0]   resp_rd_q, resp_rd_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

  logic              accept;
  logic              trap;
  logic              noop;
  logic [1:0]        eff_off;
  logic [3:0]        lane_be;
  logic [XLEN-1:0]   lane_wdata;
  logic [15:0]       shifted;
  logic [XLEN-1:0]   load_data;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = ((req_width == MEM_HALF) && req_addr[0]) ||
                ((req_width == MEM_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif
  assign noop = (req_width == MEM_NONE) || trap;

  // Natural-alignment offset and lane replication for the incoming request
  always_comb begin
    eff_off    = req_addr[1:0];
    lane_be    = 4'b1111;
    lane_wdata = req_wdata;
    case (req_width)
      MEM_BYTE: begin
        lane_be    = 4'b0001 << eff_off;
        lane_wdata = {4{req_wdata[7:0]}};
      end
      MEM_HALF: begin
        eff_off    = {req_addr[1], 1'b0};
        lane_be    = 4'b0011 << eff_off;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      MEM_WORD: eff_off = 2'b00;
      default: ;
    endcase
  end

  // Align and extend returned load data
  assign shifted = 16'(mem_rdata >> {off_q, 3'b000});
  always_comb begin
    load_data = mem_rdata;
    case (width_q)
      MEM_BYTE: load_data = unsigned_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      MEM_HALF: load_data = unsigned_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && !noop) state_d = S_REQ;
      S_REQ:   if (mem_gnt) state_d = mem_we_q ? S_IDLE : S_WAIT;
      S_WAIT:  if (mem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    width_d      = width_q;
    off_d        = off_q;
    unsigned_d   = unsigned_q;
    rd_d         = rd_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = resp_rd_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          width_d    = req_width;
          off_d      = eff_off;
          unsigned_d = req_unsigned;
          rd_d       = req_rd;
          if (noop) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_rd_d    = req_rd;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = req_is_store;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = lane_be;
            mem_wdata_d = lane_wdata;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_rd_d    = rd_q;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
          resp_rd_d    = rd_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      width_q      <= MEM_NONE;
      off_q        <= '0;
      unsigned_q   <= 1'b0;
      rd_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      off_q        <= off_d;
      unsigned_q   <= unsigned_d;
      rd_q         <= rd_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Only an IDLE-state response can come from a trapped request
  logic resp_mis_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             resp_mis_q <= 1'b0;
    else if (resp_valid_d) resp_mis_q <= (state_q == S_IDLE) && trap;
  end
  assign resp_misaligned = resp_mis_q;
`else
  assign resp_misaligned = 1'b0;
`endif

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = resp_rd_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a behavioural access model.
// Follows LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_load_store_unit;
  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_BYTE = 2'd1;
  localparam logic [1:0] MEM_HALF = 2'd2;
  localparam logic [1:0] MEM_WORD = 2'd3;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk, rstn;
  logic        req_valid, req_ready, req_is_store, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_width;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_misaligned;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width),
    .req_unsigned(req_unsigned), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .resp_misaligned(resp_misaligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Access rules expressed arithmetically
  function automatic bit is_mis(input logic [1:0] w, input logic [31:0] a);
    return (w == MEM_HALF && a[0]) || (w == MEM_WORD && a[1:0] != 2'b00);
  endfunction

  function automatic int unsigned lane_off(input logic [1:0] w, input logic [31:0] a);
    if (w == MEM_BYTE) return a % 4;
    if (w == MEM_HALF) return (a % 4) / 2 * 2;
    return 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] w, input logic [31:0] a);
    if (w == MEM_BYTE) return 4'(1 << lane_off(w, a));
    if (w == MEM_HALF) return 4'(3 << lane_off(w, a));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] w, input logic [31:0] d);
    if (w == MEM_BYTE) return 32'h01010101 * (d % 256);
    if (w == MEM_HALF) return 32'h00010001 * (d % 65536);
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] w, input bit uns,
                                           input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * lane_off(w, a));
    if (w == MEM_BYTE) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (w == MEM_HALF) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = d;
    end
    return v;
  endfunction

  // Present one request at the current sample point and drive the bus through its response
  task automatic do_txn(input bit st, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] w, input bit uns, input logic [4:0] rd,
                        input int gd, input int rvd, input logic [31:0] rdat,
                        output logic [31:0] got);
    bit noop;
    noop = (w == MEM_NONE) || (TRAP && is_mis(w, a));
    got  = 32'hDEAD_BEEF;
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_is_store = st; req_addr = a; req_wdata = wd;
    req_width = w; req_unsigned = uns; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_is_store = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_width = 2'($urandom); req_unsigned = 1'($urandom); req_rd = 5'($urandom);
    if (noop) begin
      check("noop_valid", 32'(resp_valid), 32'd1);
      check("noop_rdata", resp_rdata, 32'd0);
      check("noop_rd", 32'(resp_rd), 32'(rd));
      check("noop_mis", 32'(resp_misaligned), 32'(w != MEM_NONE));
      check("noop_mreq", 32'(mem_req), 32'd0);
      got = resp_rdata;
      return;
    end
    for (int i = 0; i <= gd; i++) begin
      check("req_mreq", 32'(mem_req), 32'd1);
      check("req_we", 32'(mem_we), 32'(st));
      check("req_addr", mem_addr, {a[31:2], 2'b00});
      check("req_be", 32'(mem_be), 32'(exp_be(w, a)));
      if (st) check("req_wdata", mem_wdata, exp_wdata(w, wd));
      check("req_busy", 32'(req_ready), 32'd0);
      check("req_noresp", 32'(resp_valid), 32'd0);
      mem_gnt    = (i == gd);
      mem_rvalid = (i != gd) ? 1'($urandom) : 1'b0;
      mem_rdata  = $urandom;
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("gnt_mreq", 32'(mem_req), 32'd0);
    if (st) begin
      check("st_valid", 32'(resp_valid), 32'd1);
      check("st_rdata", resp_rdata, 32'd0);
      check("st_rd", 32'(resp_rd), 32'(rd));
      check("st_mis", 32'(resp_misaligned), 32'd0);
      got = resp_rdata;
      return;
    end
    for (int i = 0; i < rvd; i++) begin
      check("wait_noresp", 32'(resp_valid), 32'd0);
      check("wait_busy", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("wait_noresp", 32'(resp_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = rdat;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    check("ld_valid", 32'(resp_valid), 32'd1);
    check("ld_rdata", resp_rdata, exp_load(w, uns, a, rdat));
    check("ld_rd", 32'(resp_rd), 32'(rd));
    check("ld_mis", 32'(resp_misaligned), 32'd0);
    got = resp_rdata;
  endtask

  // Idle cycles with stray rvalid pulses that must be ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      check("idle_noresp", 32'(resp_valid), 32'd0);
      check("idle_ready", 32'(req_ready), 32'd1);
    end
  endtask

  // Reset during REQ (in_wait=0) or WAIT (in_wait=1), then late rvalid pulses
  task automatic reset_mid(input bit in_wait);
    req_valid = 1'b1; req_is_store = 1'b0; req_addr = 32'h2002; req_width = MEM_HALF;
    req_unsigned = 1'b0; req_rd = 5'd7; req_wdata = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (in_wait) begin
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
    end else begin
      check("rst_pre_mreq", 32'(mem_req), 32'd1);
    end
    rstn = 1'b0;
    #1;
    check("rst_mreq", 32'(mem_req), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_noresp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = $urandom;
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_gnt = 1'b0;
      check("rst_late_noresp", 32'(resp_valid), 32'd0);
      check("rst_late_ready", 32'(req_ready), 32'd1);
      check("rst_late_mreq", 32'(mem_req), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] got;
    rstn = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0; req_wdata = '0;
    req_width = MEM_NONE; req_unsigned = 1'b0; req_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #2;
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_valid", 32'(resp_valid), 32'd0);
    check("reset_rdata", resp_rdata, 32'd0);
    check("reset_rd", 32'(resp_rd), 32'd0);
    check("reset_mis", 32'(resp_misaligned), 32'd0);
    check("reset_mreq", 32'(mem_req), 32'd0);
    check("reset_we", 32'(mem_we), 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_be", 32'(mem_be), 32'd0);
    check("reset_wdata", mem_wdata, 32'd0);
    #8 rstn = 1'b1;
    @(posedge clk); #1;

    do_txn(1'b1, 32'h1003, 32'h0000_00A5, MEM_BYTE, 1'b0, 5'd3, 0, 0, 32'd0, got);
    idle(1);
    do_txn(1'b0, 32'h2001, 32'd0, MEM_BYTE, 1'b0, 5'd4, 0, 0, 32'h0000_8000, got);
    check("lb_const", got, 32'hFFFF_FF80);
    idle(1);
    do_txn(1'b0, 32'h2001, 32'd0, MEM_BYTE, 1'b1, 5'd5, 0, 0, 32'h0000_8000, got);
    check("lbu_const", got, 32'h0000_0080);
    idle(1);
    do_txn(1'b0, 32'h2002, 32'd0, MEM_HALF, 1'b0, 5'd9, 3, 1, 32'h1234_5678, got);
    check("lh_const", got, 32'h0000_1234);
    idle(1);
    do_txn(1'b0, 32'h3002, 32'd0, MEM_WORD, 1'b0, 5'd10, 0, 0, 32'hCAFE_F00D, got);
    check("lw_mis_const", got, TRAP ? 32'd0 : 32'hCAFE_F00D);
    idle(1);
    do_txn(1'b1, 32'h4000, 32'h89AB_CDEF, MEM_WORD, 1'b0, 5'd11, 0, 0, 32'd0, got);
    do_txn(1'b0, 32'h4000, 32'd0, MEM_WORD, 1'b1, 5'd12, 0, 0, 32'h89AB_CDEF, got);
    check("b2b_lw_const", got, 32'h89AB_CDEF);
    do_txn(1'b0, 32'h4000, 32'd0, MEM_NONE, 1'b0, 5'd13, 0, 0, 32'd0, got);
    idle(1);

    reset_mid(1'b1);
    reset_mid(1'b0);

    for (int t = 0; t < 300; t++) begin
      do_txn(1'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom), 5'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, got);
      idle(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
